// File: rtl/read2control_pkg.sv
// Shared definitions for the output-buffer read/write controllers.
// Latency: n/a (types, constants and index helpers only).
// Backpressure: n/a.
package read2control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // Flat buffer index of (lane, column) in the X_MESH x X_MAC BRAM array.
  function automatic int buf_idx(input int lane, input int col, input int x_mac);
    return col + lane * x_mac;
  endfunction

  // LSB of a field of width w belonging to buffer (lane, column) on a flattened bus.
  function automatic int buf_lsb(input int lane, input int col, input int x_mac, input int w);
    return buf_idx(lane, col, x_mac) * w;
  endfunction

endpackage

// File: rtl/read2control_wordfifo.sv
// Two-entry word FIFO holding one MAC column's words for all mesh lanes.
// Latency: a pushed word is visible at head_o the cycle after the push.
// Backpressure: none internally; the caller's credit rule keeps count_o <= 2.
module read2control_wordfifo #(
  parameter int W = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  // Storage, pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/read2control.sv
// Streams one line of packed bytes from a selected MAC column of the BRAM array, one byte per lane per beat.
// Latency: first beat RD_LAT+1 cycles after the first read issue; then one beat per cycle.
// Backpressure: out_ready=0 holds the beat; reads continue only while FIFO + in-flight words < 2.
module read2control
  import read2control_pkg::*;
#(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int ADDR_LEN     = 13,
  parameter int DATA_LEN     = 32,
  parameter int MAX_LINE_LEN = 10,
  parameter int RD_LAT       = 1,
  parameter int BUFFER_NUM   = X_MAC * X_MESH,
  parameter int ADDRWIDTH    = BUFFER_NUM * ADDR_LEN,
  parameter int DATAWIDTH    = BUFFER_NUM * DATA_LEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_LEN*X_MAC-1:0] st_addr,
  input  logic [MAX_LINE_LEN-1:0]   linelen,
  input  logic [1:0]                valid_mac,
  input  logic                      conf_input,
  output logic [ADDRWIDTH-1:0]      addrb,
  output logic [BUFFER_NUM-1:0]     enb,
  input  logic [DATAWIDTH-1:0]      doutb,
  output logic [8*X_MESH-1:0]       out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      idle
);

  localparam int FW = DATA_LEN * X_MESH;

  state_t                  state_q, state_d;
  logic [ADDR_LEN-1:0]     waddr_q, waddr_d;
  logic [MAX_LINE_LEN-1:0] words_left_q, words_left_d;
  logic [MAX_LINE_LEN-1:0] bytes_left_q, bytes_left_d;
  logic [1:0]              mac_q, mac_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [RD_LAT-1:0]       vpipe_q;

  logic [MAX_LINE_LEN:0]   len_plus3;
  logic [MAX_LINE_LEN-1:0] words_init;
  logic [1:0]              inflight;
  logic [1:0]              fifo_count;
  logic [FW-1:0]           fifo_head;
  logic [FW-1:0]           push_dat;
  logic                    issue, push, hs, pop, last_byte;

  // Words needed for the line, rounding a partial last word up.
  assign len_plus3  = {1'b0, linelen} + (MAX_LINE_LEN + 1)'(3);
  assign words_init = MAX_LINE_LEN'(len_plus3 >> 2);

  // Count reads whose data has not yet come back from the BRAM.
  always_comb begin
    inflight = 2'd0;
    for (int k = 0; k < RD_LAT; k++) begin
      inflight = inflight + {1'b0, vpipe_q[k]};
    end
  end

  assign issue = (state_q == ST_RUN) && (words_left_q != '0) &&
                 (({1'b0, fifo_count} + {1'b0, inflight}) < 3'd2);
  assign push      = vpipe_q[RD_LAT-1];
  assign out_valid = (fifo_count != 2'd0);
  assign hs        = out_valid & out_ready;
  assign last_byte = (bytes_left_q == MAX_LINE_LEN'(1));
  assign pop       = hs & ((byte_idx_q == 2'd3) | last_byte);
  assign out_last  = out_valid & last_byte;
  assign busy      = (state_q != ST_IDLE);
  assign idle      = !busy && (fifo_count == 2'd0) && (inflight == 2'd0);

  // Select the active column's returning word from every lane.
  always_comb begin
    push_dat = '0;
    for (int i = 0; i < X_MESH; i++) begin
      push_dat[i*DATA_LEN +: DATA_LEN] = doutb[buf_lsb(i, int'(mac_q), X_MAC, DATA_LEN) +: DATA_LEN];
    end
  end

  // Drive the active column's address to every lane; idle columns stay at zero.
  always_comb begin
    addrb = '0;
    enb   = '0;
    for (int i = 0; i < X_MESH; i++) begin
      for (int j = 0; j < X_MAC; j++) begin
        if (2'(j) == mac_q) begin
          addrb[buf_lsb(i, j, X_MAC, ADDR_LEN) +: ADDR_LEN] = waddr_q;
          enb[buf_idx(i, j, X_MAC)]                         = issue;
        end
      end
    end
  end

  // Byte lane mux; the bus reads zero whenever no beat is offered.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < X_MESH; i++) begin
      if (out_valid) begin
        out_data[i*8 +: 8] = fifo_head[i*DATA_LEN + int'(byte_idx_q)*8 +: 8];
      end
    end
  end

  // Next-state: config latch in idle, run/drain transitions, then counter updates.
  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    words_left_d = words_left_q;
    bytes_left_d = bytes_left_q;
    mac_d        = mac_q;
    byte_idx_d   = byte_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (conf_input && (linelen != '0)) begin
          state_d      = ST_RUN;
          mac_d        = valid_mac;
          waddr_d      = st_addr[int'(valid_mac)*ADDR_LEN +: ADDR_LEN];
          words_left_d = words_init;
          bytes_left_d = linelen;
          byte_idx_d   = 2'd0;
        end
      end
      ST_RUN: begin
        if (issue && (words_left_q == MAX_LINE_LEN'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (hs && out_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      waddr_d      = waddr_q + ADDR_LEN'(1);
      words_left_d = words_left_q - MAX_LINE_LEN'(1);
    end
    if (hs) begin
      bytes_left_d = bytes_left_q - MAX_LINE_LEN'(1);
      byte_idx_d   = pop ? 2'd0 : byte_idx_q + 2'd1;
    end
  end

  // State, counters and the read-latency valid pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      waddr_q      <= '0;
      words_left_q <= '0;
      bytes_left_q <= '0;
      mac_q        <= 2'd0;
      byte_idx_q   <= 2'd0;
      vpipe_q      <= '0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      words_left_q <= words_left_d;
      bytes_left_q <= bytes_left_d;
      mac_q        <= mac_d;
      byte_idx_q   <= byte_idx_d;
      vpipe_q[0]   <= issue;
      for (int k = 1; k < RD_LAT; k++) begin
        vpipe_q[k] <= vpipe_q[k-1];
      end
    end
  end

  read2control_wordfifo #(.W(FW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count)
  );

endmodule

// File: tb/tb_read2control.sv
// Bench for read2control: two instances (RD_LAT=1 and RD_LAT=2) share stimulus.
// Each has its own BRAM model; a monitor logs reads and beats, checks compare them to the line model.
module tb_read2control;

  localparam int NB = 64;

  logic clk;
  logic rst_n;
  logic [51:0] st_addr;
  logic [9:0]  linelen;
  logic [1:0]  valid_mac;
  logic        conf_input;
  logic        out_ready;

  logic [831:0]  addrb     [2];
  logic [63:0]   enb       [2];
  logic [2047:0] doutb     [2];
  logic [127:0]  out_data  [2];
  logic          out_valid [2];
  logic          out_last  [2];
  logic          busy      [2];
  logic          idle      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    read2control #(.RD_LAT(g + 1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .st_addr    (st_addr),
      .linelen    (linelen),
      .valid_mac  (valid_mac),
      .conf_input (conf_input),
      .addrb      (addrb[g]),
      .enb        (enb[g]),
      .doutb      (doutb[g]),
      .out_data   (out_data[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready),
      .out_last   (out_last[g]),
      .busy       (busy[g]),
      .idle       (idle[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] seed;
  int cur_m = 0;
  int clr_tok = 0;

  // Contents of BRAM (lane i, column j) at word address a.
  function automatic logic [31:0] bword(input int i, input int j, input int a);
    return seed ^ (32'(a) * 32'h9E3779B1) ^ (32'(i) << 24) ^ (32'(j) << 20);
  endfunction

  // BRAM model: registered read, plus an extra output register for the RD_LAT=2 instance.
  logic [31:0] rd1 [2][NB];
  logic [31:0] st2 [2][NB];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      for (int b = 0; b < NB; b++) begin
        if (enb[g][b]) rd1[g][b] <= bword(b / 4, b % 4, int'(addrb[g][b*13 +: 13]));
        st2[g][b] <= rd1[g][b];
      end
    end
  end
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      doutb[g] = '0;
      for (int b = 0; b < NB; b++) begin
        doutb[g][b*32 +: 32] = (g == 0) ? rd1[g][b] : st2[g][b];
      end
    end
  end

  // Monitor state.
  logic [127:0] b_dat [2][NB];
  logic         b_last [2][NB];
  int           b_cyc [2][NB];
  int           n_b [2], rd_a [2][NB], n_rd [2], bad_en [2], stall_err [2];
  int           max_out [2], consumed [2], b_in_word [2], saw_nonidle [2];
  logic         held_v [2], held_l [2];
  logic [127:0] held_d [2];
  int           cyc = 0, conf_cyc = 0, last_tok = -1;

  always @(negedge clk) begin
    logic [63:0] mk;
    logic ok;
    cyc++;
    if (clr_tok != last_tok) begin
      last_tok = clr_tok;
      for (int g = 0; g < 2; g++) begin
        n_b[g] = 0; n_rd[g] = 0; bad_en[g] = 0; stall_err[g] = 0; max_out[g] = 0;
        consumed[g] = 0; b_in_word[g] = 0; held_v[g] = 1'b0; saw_nonidle[g] = 0;
      end
    end
    if (conf_input) conf_cyc = cyc;
    mk = '0;
    for (int i = 0; i < 16; i++) mk[cur_m + i*4] = 1'b1;
    for (int g = 0; g < 2; g++) begin
      if (busy[g] || !idle[g] || out_valid[g] || enb[g] != '0) saw_nonidle[g] = 1;
      if (enb[g] != '0) begin
        ok = (enb[g] === mk);
        for (int b = 0; b < NB; b++) begin
          if (b % 4 == cur_m) ok = ok && (addrb[g][b*13 +: 13] === addrb[g][cur_m*13 +: 13]);
          else                ok = ok && (addrb[g][b*13 +: 13] === 13'd0);
        end
        if (!ok) bad_en[g]++;
        if (n_rd[g] < NB) rd_a[g][n_rd[g]] = int'(addrb[g][cur_m*13 +: 13]);
        n_rd[g]++;
      end
      if (n_rd[g] - consumed[g] > max_out[g]) max_out[g] = n_rd[g] - consumed[g];
      if (held_v[g] && (out_valid[g] !== 1'b1 || out_data[g] !== held_d[g] || out_last[g] !== held_l[g]))
        stall_err[g]++;
      held_v[g] = out_valid[g] && !out_ready;
      held_d[g] = out_data[g];
      held_l[g] = out_last[g];
      if (out_valid[g] && out_ready) begin
        if (n_b[g] < NB) begin
          b_dat[g][n_b[g]] = out_data[g];
          b_last[g][n_b[g]] = out_last[g];
          b_cyc[g][n_b[g]] = cyc;
        end
        n_b[g]++;
        b_in_word[g]++;
        if (b_in_word[g] == 4 || out_last[g]) begin
          consumed[g]++;
          b_in_word[g] = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input int g, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, g, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 4 == 0) || (c % 4 == 3);
    return ($urandom_range(0, 9) < 7);
  endfunction

  task automatic rand_cfg();
    logic [63:0] r;
    r = {$urandom, $urandom};
    st_addr   = r[51:0];
    linelen   = 10'($urandom_range(1, 1023));
    valid_mac = 2'($urandom_range(0, 3));
  endtask

  // Compare everything the monitor logged against the line model.
  task automatic check_line(input int m, input int st, input int len, input int mode, input bit lat_ok);
    int nw;
    logic [127:0] exp;
    logic [31:0] wv;
    nw = (len + 3) / 4;
    for (int g = 0; g < 2; g++) begin
      chk("nreads", g, n_rd[g], nw);
      for (int w = 0; w < nw && w < NB; w++) chk("rdaddr", g, rd_a[g][w], (st + w) % 8192);
      chk("enb_pattern", g, bad_en[g], 0);
      chk("outstanding_le2", g, (max_out[g] <= 2), 1);
      chk("stall_stable", g, stall_err[g], 0);
      chk("nbeats", g, n_b[g], len);
      for (int k = 0; k < len && k < NB; k++) begin
        exp = '0;
        for (int i = 0; i < 16; i++) begin
          wv = bword(i, m, (st + k / 4) % 8192);
          exp[i*8 +: 8] = wv[8*(k % 4) +: 8];
        end
        chk("data", g, b_dat[g][k], exp);
        chk("last", g, b_last[g][k], (k == len - 1));
      end
      if (mode == 0 && lat_ok && len > 0 && len <= NB) begin
        chk("first_beat_latency", g, b_cyc[g][0] - conf_cyc, g + 3);
        chk("back_to_back", g, b_cyc[g][len-1] - b_cyc[g][0], len - 1);
      end
      if (len == 0) chk("never_busy", g, saw_nonidle[g], 0);
      chk("idle_after", g, idle[g], 1'b1);
      chk("busy_after", g, busy[g], 1'b0);
    end
  endtask

  task automatic run_line(input int m, input int st, input int len, input int mode, input int intr);
    logic [63:0] r;
    bit done;
    r = {$urandom, $urandom};
    st_addr = r[51:0];
    st_addr[m*13 +: 13] = 13'(st);
    linelen    = 10'(len);
    valid_mac  = 2'(m);
    cur_m      = m;
    clr_tok++;
    conf_input = 1'b1;
    out_ready  = rdy(mode, 0);
    step();
    conf_input = 1'b0;
    rand_cfg();
    done = 1'b0;
    for (int c = 1; c < 600; c++) begin
      out_ready = rdy(mode, c);
      if (c == intr) begin
        rand_cfg();
        conf_input = 1'b1;
      end
      step();
      conf_input = 1'b0;
      if (c > 3 && idle[0] && idle[1]) begin
        done = 1'b1;
        break;
      end
    end
    chk("line_done", 0, done, 1'b1);
    out_ready = 1'b1;
    repeat (3) step();
    check_line(m, st, len, mode, intr < 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb0 [2];
    seed       = $urandom;
    rst_n      = 1'b0;
    st_addr    = '0;
    linelen    = '0;
    valid_mac  = '0;
    conf_input = 1'b0;
    out_ready  = 1'b0;
    repeat (3) step();
    for (int g = 0; g < 2; g++) begin
      chk("rst_out_valid", g, out_valid[g], 1'b0);
      chk("rst_out_data", g, out_data[g], '0);
      chk("rst_out_last", g, out_last[g], 1'b0);
      chk("rst_enb", g, enb[g], '0);
      chk("rst_addrb", g, addrb[g], '0);
      chk("rst_busy", g, busy[g], 1'b0);
      chk("rst_idle", g, idle[g], 1'b1);
    end
    rst_n = 1'b1;
    step();

    run_line(1, 100, 8, 0, -1);
    run_line(3, 2000, 6, 0, -1);
    run_line(2, 500, 16, 1, -1);
    run_line(0, 8190, 12, 2, -1);
    run_line(2, 777, 16, 1, 5);

    // Reset in the middle of a line.
    st_addr    = '0;
    st_addr[12:0] = 13'd50;
    linelen    = 10'd40;
    valid_mac  = 2'd0;
    cur_m      = 0;
    clr_tok++;
    conf_input = 1'b1;
    out_ready  = 1'b1;
    step();
    conf_input = 1'b0;
    repeat (8) step();
    for (int g = 0; g < 2; g++) chk("midline_busy", g, busy[g], 1'b1);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("arst_out_valid", g, out_valid[g], 1'b0);
      chk("arst_out_data", g, out_data[g], '0);
      chk("arst_out_last", g, out_last[g], 1'b0);
      chk("arst_enb", g, enb[g], '0);
      chk("arst_busy", g, busy[g], 1'b0);
      chk("arst_idle", g, idle[g], 1'b1);
      nb0[g] = n_b[g];
    end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    for (int g = 0; g < 2; g++) chk("no_beats_after_rst", g, n_b[g], nb0[g]);
    run_line(1, 300, 10, 2, -1);

    run_line(0, 10, 0, 0, -1);

    for (int r = 0; r < 4; r++) begin
      run_line(int'($urandom_range(0, 3)), int'($urandom_range(0, 8191)),
               int'($urandom_range(1, 40)), 2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
